// File: rtl/mod_74x04_arb_pkg.sv
// Shared constants and state encoding for the 4-way arbiter around the 5-bit inverter bank.
package mod_74x04_arb_pkg;

    localparam int unsigned ARB_NREQ = 4;
    localparam int unsigned ARB_W    = 5;
    localparam int unsigned GNT_W    = 2;
    localparam int unsigned DONE_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        RESP  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mod_74x04_5.sv
// W-bit hex-inverter style bank: Y is the bitwise complement of A.
module mod_74x04_5 #(
    parameter int unsigned W = mod_74x04_arb_pkg::ARB_W
) (
    input  logic [W-1:0] A,
    output logic [W-1:0] Y
);

    assign Y = ~A;

endmodule

// File: rtl/mod_74x04_5_arb.sv
// Round-robin arbiter feeding one shared inverter bank; one transaction in flight at a time.
module mod_74x04_5_arb
    import mod_74x04_arb_pkg::*;
#(
    parameter int unsigned NREQ = ARB_NREQ,
    parameter int unsigned W    = ARB_W
) (
    input  logic                CLK,
    input  logic                CLR_N,
    input  logic [NREQ-1:0]     REQ_VALID,
    output logic [NREQ-1:0]     REQ_READY,
    input  logic [NREQ*W-1:0]   REQ_DATA,
    output logic [NREQ-1:0]     RSP_VALID,
    input  logic [NREQ-1:0]     RSP_READY,
    output logic [W-1:0]        RSP_DATA,
    output logic [GNT_W-1:0]    GNT_ID,
    output logic                BUSY,
    output logic [DONE_W-1:0]   DONE_CNT
);

    arb_state_e             state_q, state_d;
    logic [GNT_W-1:0]       ptr_q, ptr_d;
    logic [GNT_W-1:0]       gnt_q, gnt_d;
    logic [W-1:0]           a_q, a_d;
    logic [W-1:0]           rsp_data_q, rsp_data_d;
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [DONE_W-1:0]      done_q, done_d;
    logic                   busy_q, busy_d;

    logic [GNT_W-1:0]       cand;
    logic [GNT_W-1:0]       win;
    logic                   win_vld;
    logic [NREQ-1:0]        req_ready_c;
    logic [W-1:0]           inv_y;
    logic [NREQ-1:0][W-1:0] req_ops;

    assign req_ops = REQ_DATA;

    mod_74x04_5 #(
        .W (W)
    ) u_inv (
        .A (a_q),
        .Y (inv_y)
    );

    // Round-robin pick: first valid requester after ptr_q, wrapping to 0
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        cand    = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = GNT_W'((int'(ptr_q) + k) % int'(NREQ));
            if (!win_vld && REQ_VALID[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    // Accept strobe to the current winner, only while idle
    always_comb begin
        req_ready_c = '0;
        if ((state_q == IDLE) && win_vld) begin
            req_ready_c[win] = 1'b1;
        end
    end

    // Next-state and datapath updates for IDLE -> DRIVE -> RESP -> IDLE
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        a_d        = a_q;
        rsp_data_d = rsp_data_q;
        done_d     = done_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    a_d     = req_ops[win];
                    gnt_d   = win;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                rsp_data_d = inv_y;
                state_d    = RESP;
            end
            RESP: begin
                if (RSP_READY[gnt_q]) begin
                    state_d = IDLE;
                    ptr_d   = gnt_q;
                    done_d  = done_q + DONE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rsp_valid_d = '0;
        if (state_d == RESP) begin
            rsp_valid_d[gnt_d] = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset gives requester 0 first priority
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q     <= IDLE;
            ptr_q       <= GNT_W'(NREQ - 1);
            gnt_q       <= '0;
            a_q         <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign REQ_READY = req_ready_c;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign GNT_ID    = gnt_q;
    assign BUSY      = busy_q;
    assign DONE_CNT  = done_q;

endmodule

// File: tb/tb_mod_74x04_5_arb.sv
// Bench for mod_74x04_5_arb: transaction model + scoreboard plus directed scenarios.
module tb_mod_74x04_5_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 5;

    logic            clk = 1'b0;
    logic            clr_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      gnt_id;
    logic            busy;
    logic [7:0]      done_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_74x04_5_arb dut (
        .CLK       (clk),
        .CLR_N     (clr_n),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_DATA  (req_data),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_DATA  (rsp_data),
        .GNT_ID    (gnt_id),
        .BUSY      (busy),
        .DONE_CNT  (done_cnt)
    );

    typedef struct packed {
        logic [1:0]    g;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb_q[$];

    // Transaction-level model: phase 0 waiting, 1 operand held, 2 response offered
    int         m_phase = 0;
    logic [1:0] m_ptr   = 2'd3;
    logic [1:0] m_gnt   = 2'd0;
    logic [7:0] m_done  = 8'd0;
    int         m_pick;
    logic [N-1:0][DW-1:0] ops;

    assign ops = req_data;

    function automatic int rr_pick(input logic [N-1:0] v, input logic [1:0] ptr);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (int'(ptr) + k) % int'(N);
            if (v[2'(idx)]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = '0;
        r[2'(i)] = 1'b1;
        return r;
    endfunction

    always_comb m_pick = rr_pick(req_valid, m_ptr);

    function automatic logic [N-1:0] exp_ready();
        if (m_phase == 0 && m_pick >= 0) return oh(m_pick);
        return '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model update and scoreboard push on each accepted request
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_phase <= 0;
            m_ptr   <= 2'(N - 1);
            m_gnt   <= '0;
            m_done  <= '0;
            sb_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (m_pick >= 0) begin
                        sb_q.push_back(exp_t'{g: 2'(m_pick), d: ~ops[2'(m_pick)]});
                        m_gnt   <= 2'(m_pick);
                        m_phase <= 1;
                    end
                end
                1: m_phase <= 2;
                default: begin
                    if (rsp_ready[m_gnt]) begin
                        m_phase <= 0;
                        m_ptr   <= m_gnt;
                        m_done  <= m_done + 8'd1;
                    end
                end
            endcase
        end
    end

    // Monitor: compare DUT outputs mid-cycle, pop when the response is taken
    always @(negedge clk) begin
        if (clr_n) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready()));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done_cnt", 32'(done_cnt), 32'(m_done));
            chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
            if (m_phase == 2) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow at %0t: got rsp_valid 0x%0h required a queued entry", $time, rsp_valid);
                end else begin
                    chk("rsp_valid", 32'(rsp_valid), 32'(oh(int'(sb_q[0].g))));
                    chk("rsp_data", 32'(rsp_data), 32'(sb_q[0].d));
                    if (rsp_ready[sb_q[0].g]) void'(sb_q.pop_front());
                end
            end else begin
                chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        clr_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '0;
        @(posedge clk); #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;
    endtask

    logic [DW-1:0] d;
    logic [DW-1:0] nd;

    initial begin
        // Single request, first accept right after reset release
        do_reset();
        req_valid = 4'b0001;
        req_data  = 20'(5'b10110);
        rsp_ready = 4'b1111;
        @(posedge clk); #1;
        chk("single_e1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("single_e1_busy", 32'(busy), 32'd1);
        req_valid = '0;
        @(posedge clk); #1;
        chk("single_e2_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("single_rsp_data", 32'(rsp_data), 32'(5'b01001));
        @(posedge clk); #1;
        chk("single_done", 32'(done_cnt), 32'd1);
        chk("single_idle", 32'(busy), 32'd0);

        // Fairness with all requesters held
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int e = 1; e <= 13; e++) begin
            req_data = 20'($urandom);
            @(posedge clk); #1;
            if (e % 3 == 1) begin
                chk("fair_gnt", 32'(gnt_id), 32'((e / 3) % 4));
                chk("fair_busy", 32'(busy), 32'd1);
                chk("fair_ready_low", 32'(req_ready), 32'd0);
            end else if (e % 3 == 0) begin
                chk("fair_idle", 32'(busy), 32'd0);
            end
        end
        req_valid = '0;
        repeat (3) begin @(posedge clk); #1; end

        // Backpressure in RESP with other requesters waiting
        do_reset();
        d = 5'($urandom);
        nd = ~d;
        req_valid = 4'b0100;
        req_data  = {5'($urandom), d, 5'($urandom), 5'($urandom)};
        rsp_ready = 4'b1011;
        @(posedge clk); #1;
        req_valid = 4'b1011;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'b0100);
            chk("bp_rsp_data", 32'(rsp_data), 32'(nd));
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 4'b0100;
        @(posedge clk); #1;
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_done", 32'(done_cnt), 32'd1);
        chk("bp_next_ready", 32'(req_ready), 32'b1000);
        req_valid = 4'b1000;
        rsp_ready = 4'b1111;
        @(posedge clk); #1;
        chk("bp_next_gnt", 32'(gnt_id), 32'd3);
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end

        // Reset while a response is pending
        req_valid = 4'b0001;
        req_data  = 20'($urandom);
        rsp_ready = 4'b0000;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("mid_pre_rsp_valid", 32'(rsp_valid), 32'b0001);
        #2;
        clr_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_done", 32'(done_cnt), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr_n     = 1'b1;
        req_valid = 4'b1010;
        rsp_ready = 4'b1111;
        @(posedge clk); #1;
        chk("mid_after_gnt", 32'(gnt_id), 32'd1);
        chk("mid_after_no_stale", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        @(posedge clk); #1;
        chk("mid_after_rsp", 32'(rsp_valid), 32'b0010);
        repeat (2) begin @(posedge clk); #1; end

        // 256 back-to-back transactions sweeping operands 0..31
        do_reset();
        rsp_ready = 4'b1111;
        for (int t = 0; t < 256; t++) begin
            if (t == 255) chk("wrap_done_255", 32'(done_cnt), 32'd255);
            req_valid = 4'b1111;
            req_data  = {4{5'(t)}};
            nd = ~5'(t);
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("sweep_rsp_data", 32'(rsp_data), 32'(nd));
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("wrap_done_0", 32'(done_cnt), 32'd0);
        repeat (2) begin @(posedge clk); #1; end

        // Randomized traffic: valids rise and drop freely, random backpressure
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            else req_valid = 4'($urandom);
            req_data  = 20'($urandom);
            rsp_ready = 4'($urandom);
            @(posedge clk); #1;
        end

        req_valid = '0;
        rsp_ready = 4'b1111;
        repeat (4) begin @(posedge clk); #1; end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
